// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined MIPS fetch path.
package cpu_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC  = 30'h00100000;
  localparam logic [ADDR_W-1:0] MEM_LAST  = 30'h00100100;
  localparam logic [INST_W-1:0] HALT_INST = 32'h0000000C;
  localparam logic [INST_W-1:0] NOP_INST  = 32'h00000000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Legal fetch window, unsigned and inclusive at both ends.
  function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr);
    return (addr >= RESET_PC) && (addr <= MEM_LAST);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory, EX redirect, decode handoff and status.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output id_valid,
    output id_inst,
    output id_pc,
    output id_pc_plus1,
    output halted,
    output fault,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output stall,
    output redirect_valid,
    output redirect_target,
    input  id_valid,
    input  id_inst,
    input  id_pc,
    input  id_pc_plus1,
    input  halted,
    input  fault,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, so a redirect clears it even while stalled.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_pc_plus1,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus1
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_plus1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_inst     <= NOP_INST;
      r_pc       <= '0;
      r_pc_plus1 <= '0;
    end else if (i_flush) begin
      // Bubble keeps the last pc fields; only valid/inst are cleared.
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (i_en) begin
      r_valid    <= 1'b1;
      r_inst     <= i_inst;
      r_pc       <= i_pc;
      r_pc_plus1 <= i_pc_plus1;
    end
  end

  assign o_valid    = r_valid;
  assign o_inst     = r_inst;
  assign o_pc       = r_pc;
  assign o_pc_plus1 = r_pc_plus1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, RUN/HALT/FAULT control and delivered-instruction counter.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_fetch_count;
  logic              r_halted;
  logic              r_fault;

  logic              w_in_window;
  logic              w_deliver;
  logic              w_flush;
  logic [ADDR_W-1:0] w_pc_plus1;

  assign w_in_window = addr_in_window(r_pc);
  assign w_pc_plus1  = ADDR_W'(r_pc + ADDR_W'(1));
  assign w_deliver   = (r_state == RUN) && w_in_window &&
                       !bus.stall && !bus.redirect_valid;
  assign w_flush     = bus.redirect_valid || (!bus.stall && !w_deliver);

  // Priority per edge: reset, redirect, stall, then state-dependent fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_state  <= RUN;
      r_pc     <= bus.redirect_target;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (!bus.stall) begin
      case (r_state)
        RUN: begin
          if (w_in_window) begin
            if (r_fetch_count != '1)
              r_fetch_count <= CNT_W'(r_fetch_count + CNT_W'(1));
            if (bus.imem_inst == HALT_INST) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_plus1;
            end
          end else begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_en       (!bus.stall),
    .i_flush    (w_flush),
    .i_inst     (bus.imem_inst),
    .i_pc       (r_pc),
    .i_pc_plus1 (w_pc_plus1),
    .o_valid    (bus.id_valid),
    .o_inst     (bus.id_inst),
    .o_pc       (bus.id_pc),
    .o_pc_plus1 (bus.id_pc_plus1)
  );

  assign bus.imem_addr   = r_pc;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a zero-latency instruction memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mem [0:511];

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory covers 512 words from RESET_PC; anything else reads as zero.
  always_comb begin
    logic [29:0] off;
    off = bus.imem_addr - RESET_PC;
    if (bus.imem_addr >= RESET_PC && off < 30'd512)
      bus.imem_inst = mem[off[8:0]];
    else
      bus.imem_inst = 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0]   = 32'h20080001;
    mem[1]   = 32'h20090002;
    mem[2]   = 32'h01095020;
    mem[3]   = 32'h00000000;
    mem[4]   = 32'h2010BEEF;
    mem[5]   = 32'h0000000C;
    mem[16]  = 32'h12345678;
    mem[256] = 32'hCAFEF00D;

    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    // Reset state
    reset = 1'b1;
    step();
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_inst", bus.id_inst, 32'h0);
    chk("rst_pc", 32'(bus.id_pc), 32'h0);
    chk("rst_pc1", 32'(bus.id_pc_plus1), 32'h0);
    chk("rst_cnt", bus.fetch_count, 32'd0);
    chk("rst_halt", 32'(bus.halted), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h00100000);
    reset = 1'b0;

    // Sequential fetch of four words
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_pc", 32'(bus.id_pc), 32'h00100000 + 32'(i));
      chk("seq_pc1", 32'(bus.id_pc_plus1), 32'h00100001 + 32'(i));
      chk("seq_inst", bus.id_inst, mem[i]);
      chk("seq_valid", 32'(bus.id_valid), 32'd1);
    end
    chk("seq_cnt", bus.fetch_count, 32'd4);
    chk("seq_addr", 32'(bus.imem_addr), 32'h00100004);

    // Stall after the second fetch
    reset = 1'b1; step(); reset = 1'b0;
    step(); step();
    chk("pre_stall_inst", bus.id_inst, 32'h20090002);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", 32'(bus.imem_addr), 32'h00100002);
      chk("stall_inst", bus.id_inst, 32'h20090002);
      chk("stall_cnt", bus.fetch_count, 32'd2);
    end
    bus.stall = 1'b0;
    step();
    chk("resume_pc", 32'(bus.id_pc), 32'h00100002);
    chk("resume_inst", bus.id_inst, 32'h01095020);
    chk("resume_cnt", bus.fetch_count, 32'd3);

    // Redirect wins over stall and costs one bubble
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 30'h00100010;
    step();
    chk("redir_valid", 32'(bus.id_valid), 32'd0);
    chk("redir_inst", bus.id_inst, 32'h0);
    chk("redir_addr", 32'(bus.imem_addr), 32'h00100010);
    chk("redir_cnt", bus.fetch_count, 32'd3);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk("redir_tgt_pc", 32'(bus.id_pc), 32'h00100010);
    chk("redir_tgt_valid", 32'(bus.id_valid), 32'd1);
    chk("redir_tgt_inst", bus.id_inst, 32'h12345678);
    chk("redir_tgt_cnt", bus.fetch_count, 32'd4);

    // Syscall halts fetch after being delivered
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_sys_halt", 32'(bus.halted), 32'd0);
    step();
    chk("sys_inst", bus.id_inst, 32'h0000000C);
    chk("sys_valid", 32'(bus.id_valid), 32'd1);
    chk("sys_pc", 32'(bus.id_pc), 32'h00100005);
    chk("sys_halt", 32'(bus.halted), 32'd1);
    chk("sys_addr", 32'(bus.imem_addr), 32'h00100005);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_valid", 32'(bus.id_valid), 32'd0);
      chk("halt_inst", bus.id_inst, 32'h0);
      chk("halt_addr", 32'(bus.imem_addr), 32'h00100005);
      chk("halt_sticky", 32'(bus.halted), 32'd1);
      chk("halt_cnt", bus.fetch_count, 32'd6);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 30'h00100000;
    step();
    chk("unhalt", 32'(bus.halted), 32'd0);
    chk("unhalt_valid", 32'(bus.id_valid), 32'd0);
    chk("unhalt_addr", 32'(bus.imem_addr), 32'h00100000);
    bus.redirect_valid = 1'b0;
    step();
    chk("unhalt_pc", 32'(bus.id_pc), 32'h00100000);
    chk("unhalt_fetch", 32'(bus.id_valid), 32'd1);
    chk("unhalt_cnt", bus.fetch_count, 32'd7);

    // MEM_LAST is still legal; one past it faults
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 30'h00100100;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("last_pc", 32'(bus.id_pc), 32'h00100100);
    chk("last_inst", bus.id_inst, 32'hCAFEF00D);
    chk("last_valid", 32'(bus.id_valid), 32'd1);
    chk("last_cnt", bus.fetch_count, 32'd8);
    chk("last_nofault", 32'(bus.fault), 32'd0);
    step();
    chk("edge_fault", 32'(bus.fault), 32'd1);
    chk("edge_valid", 32'(bus.id_valid), 32'd0);
    chk("edge_cnt", bus.fetch_count, 32'd8);

    bus.redirect_valid = 1'b1;
    bus.redirect_target = 30'h00100000;
    step();
    chk("unfault", 32'(bus.fault), 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    chk("unfault_pc", 32'(bus.id_pc), 32'h00100000);
    chk("unfault_valid", 32'(bus.id_valid), 32'd1);
    chk("unfault_cnt", bus.fetch_count, 32'd9);

    bus.redirect_valid = 1'b1;
    bus.redirect_target = 30'h00100101;
    step();
    chk("oow_bubble", 32'(bus.id_valid), 32'd0);
    chk("oow_nofault_yet", 32'(bus.fault), 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    chk("oow_fault", 32'(bus.fault), 32'd1);
    chk("oow_valid", 32'(bus.id_valid), 32'd0);
    chk("oow_cnt", bus.fetch_count, 32'd9);
    step();
    chk("oow_sticky", 32'(bus.fault), 32'd1);
    chk("oow_addr", 32'(bus.imem_addr), 32'h00100101);
    reset = 1'b1;
    step();
    chk("rst_fault_clr", 32'(bus.fault), 32'd0);
    chk("rst_fault_addr", 32'(bus.imem_addr), 32'h00100000);
    chk("rst_fault_cnt", bus.fetch_count, 32'd0);
    reset = 1'b0;

    // Counter saturation
    bus.stall = 1'b1;
    force dut.r_fetch_count = 32'hFFFFFFFE;
    step();
    release dut.r_fetch_count;
    step();
    chk("sat_preload", bus.fetch_count, 32'hFFFFFFFE);
    bus.stall = 1'b0;
    step();
    chk("sat_1", bus.fetch_count, 32'hFFFFFFFF);
    step();
    chk("sat_2", bus.fetch_count, 32'hFFFFFFFF);
    step();
    chk("sat_3", bus.fetch_count, 32'hFFFFFFFF);
    chk("sat_pc", 32'(bus.id_pc), 32'h00100002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
